// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the seven-segment scan driver.
//   SEG7_HEX  : active-low {g,f,e,d,c,b,a} patterns for hex digits 0-F
//   SEG7_OFF  : all segments dark
//   AN_OFF    : all anodes off (active-low)
//   seg7_word_t : one displayable word (8 nibbles + 8 decimal points)
//   lz_mask() : leading-zero blank mask for a word. It is only used when
//               SEG7_LZ_BLANK_EN is defined.
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG7_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF   = 8'hFF;

  // Index is the nibble value. A low bit lights the segment.
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  typedef struct packed {
    logic [31:0] bcd;
    logic [7:0]  dp;
  } seg7_word_t;

  // Digit k (k >= 1) is blanked when nibbles k..7 are all zero and its own
  // decimal point is off. Digit 0 always shows.
  function automatic logic [7:0] lz_mask(input seg7_word_t w);
    logic [7:0] m;
    logic       zero_run;
    m        = '0;
    zero_run = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      zero_run = zero_run & (w.bcd[k*4 +: 4] == 4'h0);
      m[k]     = zero_run & ~w.dp[k];
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Purely combinational hex-to-seven-segment lookup.
//   nibble   : 4-bit digit value 0-F
//   segments : active-low {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = SEG7_HEX[nibble];

endmodule

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Time-multiplexed 8-digit seven-segment driver. A loaded word is held in a
// pending register and promoted to the display register only at a frame
// boundary. This keeps each frame coherent.
//
// Parameters:
//   SCAN_DIV : clock cycles per digit slot (>= 4)
//   GUARD    : all-anodes-off cycles at the start of each slot (< SCAN_DIV)
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   bcd_i     : packed digits, nibble k is digit k
//   dp_i      : decimal-point enables, bit k is digit k (active-high)
//   load_i    : capture strobe
//   pending_o : a captured word is waiting for the frame boundary
//   an_o      : digit anodes, active-low
//   seg_o     : segments {g,f,e,d,c,b,a}, active-low
//   dp_o      : decimal point, active-low
// Build option:
//   SEG7_LZ_BLANK_EN : when defined, leading zeros are blanked. The mask is
//                      computed when a word is promoted.
// -----------------------------------------------------------------------------
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bcd_i,
  input  logic [7:0]  dp_i,
  input  logic        load_i,
  output logic        pending_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int             DW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]  GUARD_END = DW'(GUARD);

  logic [DW-1:0] div_cnt_reg;
  logic [2:0]    dig_reg;
  logic          div_wrap;
  logic          frame_end;

  seg7_word_t    load_word;
  seg7_word_t    pend_reg;
  seg7_word_t    disp_reg;
  seg7_word_t    promote_word;
  logic          pending_reg;
  logic          disp_load;
  logic [7:0]    blank_reg;
  logic [7:0]    blank_next;

  logic [3:0]    nib [8];
  logic [6:0]    dec_seg;

  logic [7:0]    an_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;

  // ---------------------------------------------------------------------------
  // Slot divider and digit index
  // ---------------------------------------------------------------------------
  assign div_wrap  = (div_cnt_reg == DIV_LAST);
  assign frame_end = div_wrap && (dig_reg == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      dig_reg     <= 3'd0;
    end else if (div_wrap) begin
      div_cnt_reg <= '0;
      dig_reg     <= dig_reg + 3'd1;   // 3-bit index wraps 7 -> 0 naturally
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending / display registers
  // A load on the boundary cycle bypasses the pending register. The newest
  // word is then promoted directly, and pending never rises.
  // ---------------------------------------------------------------------------
  assign load_word    = '{bcd: bcd_i, dp: dp_i};
  assign promote_word = load_i ? load_word : pend_reg;
  assign disp_load    = frame_end && (load_i || pending_reg);

`ifdef SEG7_LZ_BLANK_EN
  assign blank_next = lz_mask(promote_word);
`else
  assign blank_next = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg    <= '0;
      disp_reg    <= '0;
      blank_reg   <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (disp_load) begin
        disp_reg  <= promote_word;
        blank_reg <= blank_next;
      end
      if (load_i && !frame_end) begin
        pend_reg    <= load_word;
        pending_reg <= 1'b1;
      end else if (frame_end) begin
        pending_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select and decode
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign nib[gi] = disp_reg.bcd[gi*4 +: 4];
  end

  seg7_decode u_decode (
    .nibble   (nib[dig_reg]),
    .segments (dec_seg)
  );

  // ---------------------------------------------------------------------------
  // Output registers. They lag the counters by one cycle, so pins never see
  // a combinational path from inputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg  <= AN_OFF;
      seg_reg <= SEG7_OFF;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= (div_cnt_reg < GUARD_END) ? AN_OFF : ~(8'b1 << dig_reg);
      seg_reg <= blank_reg[dig_reg] ? SEG7_OFF : dec_seg;
      dp_reg  <= ~disp_reg.dp[dig_reg];
    end
  end

  assign an_o      = an_reg;
  assign seg_o     = seg_reg;
  assign dp_o      = dp_reg;
  assign pending_o = pending_reg;

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

  localparam int SD = 8;
  localparam int GD = 2;
`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_i = 1'b0;
  logic [31:0] bcd_i = '0;
  logic [7:0]  dp_i = '0;
  logic        pending_o;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_i     (bcd_i),
    .dp_i      (dp_i),
    .load_i    (load_i),
    .pending_o (pending_o),
    .an_o      (an_o),
    .seg_o     (seg_o),
    .dp_o      (dp_o)
  );

  // ---------------------------------------------------------------------------
  // Reference model: time since reset gives slot/digit. The frame boundary is
  // every 64th edge. Displayed word and pending word follow the load rules.
  // ---------------------------------------------------------------------------
  int          cyc;
  logic [31:0] m_disp, m_pend;
  logic [7:0]  m_dp, m_pdp;
  logic        m_pflag;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  function automatic logic [6:0] ref_hex(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] ref_an(input int c);
    int slot_pos = c % SD;
    int d = (c / SD) % 8;
    return (slot_pos < GD) ? 8'hFF : ~(8'h01 << d);
  endfunction

  function automatic logic [6:0] ref_seg(input int c, input logic [31:0] w, input logic [7:0] dv);
    int d = (c / SD) % 8;
    logic [31:0] upper = w >> (4 * d);
    bit blank = LZ && (d > 0) && (upper == 32'd0) && !dv[d];
    return blank ? 7'h7F : ref_hex(upper[3:0]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc     <= 0;
      m_disp  <= '0;  m_dp  <= '0;
      m_pend  <= '0;  m_pdp <= '0;
      m_pflag <= 1'b0;
      exp_an  <= 8'hFF;
      exp_seg <= 7'h7F;
      exp_dp  <= 1'b1;
    end else begin
      exp_an  <= ref_an(cyc);
      exp_seg <= ref_seg(cyc, m_disp, m_dp);
      exp_dp  <= ~m_dp[(cyc / SD) % 8];
      cyc     <= cyc + 1;
      if (load_i && (cyc % 64 == 63)) begin
        m_disp <= bcd_i;  m_dp <= dp_i;  m_pflag <= 1'b0;
      end else if (load_i) begin
        m_pend <= bcd_i;  m_pdp <= dp_i;  m_pflag <= 1'b1;
      end else if ((cyc % 64 == 63) && m_pflag) begin
        m_disp <= m_pend; m_dp <= m_pdp;  m_pflag <= 1'b0;
      end
    end
  end

  // Wait (bounded) until the edge count is m modulo one frame.
  task automatic wait_mod(input int m);
    for (int i = 0; i < 130 && (cyc % 64) != m; i++) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total += 4;
    if (an_o !== 8'hFF)    begin bad++; $display("FAIL reset_an got=%h want=ff", an_o); end
    if (seg_o !== 7'h7F)   begin bad++; $display("FAIL reset_seg got=%h want=7f", seg_o); end
    if (dp_o !== 1'b1)     begin bad++; $display("FAIL reset_dp got=%b want=1", dp_o); end
    if (pending_o !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b want=0", pending_o); end
    rst_n = 1'b1;
    wait_mod(5);
    bcd_i = 32'h0000_ABCD; dp_i = 8'h00; load_i = 1'b1;
    @(negedge clk); load_i = 1'b0;
    wait_mod(13);
    total += 2;
    if (an_o !== 8'hFD)     begin bad++; $display("FAIL midframe_an got=%h want=fd", an_o); end
    if (pending_o !== 1'b1) begin bad++; $display("FAIL midframe_pending got=%b want=1", pending_o); end
    #2 rst_n = 1'b0;
    #1;
    total += 4;
    if (an_o !== 8'hFF)     begin bad++; $display("FAIL async_an got=%h want=ff", an_o); end
    if (seg_o !== 7'h7F)    begin bad++; $display("FAIL async_seg got=%h want=7f", seg_o); end
    if (dp_o !== 1'b1)      begin bad++; $display("FAIL async_dp got=%b want=1", dp_o); end
    if (pending_o !== 1'b0) begin bad++; $display("FAIL async_pending got=%b want=0", pending_o); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if (an_o !== ((i < 3) ? 8'hFF : 8'hFE)) begin
        bad++; $display("FAIL release_an cycle=%0d got=%h want=%h", i, an_o, (i < 3) ? 8'hFF : 8'hFE);
      end
    end
    $display("reset test: cyc=%0d an=%h", cyc, an_o);
  endtask

  task automatic test_guard();
    int ff_cnt [8];
    int oh_cnt [8];
    int d;
    for (int k = 0; k < 8; k++) begin ff_cnt[k] = 0; oh_cnt[k] = 0; end
    wait_mod(0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      d = ((cyc - 1) / SD) % 8;
      if (an_o === 8'hFF) ff_cnt[d]++;
      else if (an_o === ~(8'h01 << d)) oh_cnt[d]++;
    end
    for (int k = 0; k < 8; k++) begin
      total += 2;
      if (ff_cnt[k] != GD)      begin bad++; $display("FAIL guard_off slot=%0d got=%0d want=%0d", k, ff_cnt[k], GD); end
      if (oh_cnt[k] != SD - GD) begin bad++; $display("FAIL guard_on slot=%0d got=%0d want=%0d", k, oh_cnt[k], SD - GD); end
    end
    $display("guard test: slot0 off=%0d on=%0d", ff_cnt[0], oh_cnt[0]);
  endtask

  task automatic test_load_frame();
    logic [6:0] es [8];
    logic [6:0] z;
    int c, d;
    z  = LZ ? 7'h7F : 7'h40;
    es = '{7'h19, 7'h30, 7'h24, 7'h79, z, z, z, z};
    wait_mod(20);
    bcd_i = 32'h0000_1234; dp_i = 8'h00; load_i = 1'b1;
    @(negedge clk); load_i = 1'b0;
    for (int i = 0; i < 64 && (cyc % 64) != 0; i++) begin
      total++;
      if (pending_o !== 1'b1) begin bad++; $display("FAIL load_pending_high cyc=%0d got=%b want=1", cyc, pending_o); end
      @(negedge clk);
    end
    total++;
    if (pending_o !== 1'b0) begin bad++; $display("FAIL load_pending_clear cyc=%0d got=%b want=0", cyc, pending_o); end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      c = (cyc - 1) % SD; d = ((cyc - 1) / SD) % 8;
      if (c >= GD) begin
        total++;
        if (seg_o !== es[d]) begin bad++; $display("FAIL load_seg digit=%0d got=%h want=%h", d, seg_o, es[d]); end
      end
    end
    $display("load frame test: word=%h done", 32'h1234);
  endtask

  task automatic test_double_load();
    logic [6:0] es [8];
    logic [6:0] z;
    int c, d;
    z  = LZ ? 7'h7F : 7'h40;
    es = '{7'h24, 7'h24, z, z, z, z, z, z};
    wait_mod(10);
    bcd_i = 32'h11; dp_i = 8'h00; load_i = 1'b1;
    @(negedge clk); load_i = 1'b0;
    wait_mod(30);
    bcd_i = 32'h22; load_i = 1'b1;
    @(negedge clk); load_i = 1'b0;
    wait_mod(0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      c = (cyc - 1) % SD; d = ((cyc - 1) / SD) % 8;
      if (c >= GD) begin
        total += 2;
        if (seg_o !== es[d]) begin bad++; $display("FAIL double_seg digit=%0d got=%h want=%h", d, seg_o, es[d]); end
        if (seg_o === 7'h79) begin bad++; $display("FAIL double_stale digit=%0d got=%h want=not_79", d, seg_o); end
      end
    end
    $display("double load test: second word shown");
  endtask

  task automatic test_boundary_load();
    logic [6:0] es [8];
    int c, d;
    es = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    wait_mod(63);
    bcd_i = 32'h89AB_CDEF; dp_i = 8'h81; load_i = 1'b1;
    @(negedge clk); load_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      c = (cyc - 1) % SD; d = ((cyc - 1) / SD) % 8;
      total++;
      if (pending_o !== 1'b0) begin bad++; $display("FAIL boundary_pending cyc=%0d got=%b want=0", cyc, pending_o); end
      if (c >= GD) begin
        total += 2;
        if (seg_o !== es[d]) begin bad++; $display("FAIL boundary_seg digit=%0d got=%h want=%h", d, seg_o, es[d]); end
        if (dp_o !== ((d == 0 || d == 7) ? 1'b0 : 1'b1)) begin
          bad++; $display("FAIL boundary_dp digit=%0d got=%b want=%b", d, dp_o, (d == 0 || d == 7) ? 1'b0 : 1'b1);
        end
      end
    end
    $display("boundary load test: word=%h", 32'h89AB_CDEF);
  endtask

  task automatic test_lz();
    logic [6:0] es [8];
    logic [6:0] z;
    int c, d;
    z  = LZ ? 7'h7F : 7'h40;
    es = '{7'h40, 7'h12, 7'h40, z, z, z, z, z};
    wait_mod(40);
    bcd_i = 32'h0000_0050; dp_i = 8'h04; load_i = 1'b1;
    @(negedge clk); load_i = 1'b0;
    wait_mod(0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      c = (cyc - 1) % SD; d = ((cyc - 1) / SD) % 8;
      if (c >= GD) begin
        total += 2;
        if (seg_o !== es[d]) begin bad++; $display("FAIL lz_seg digit=%0d got=%h want=%h", d, seg_o, es[d]); end
        if (dp_o !== ((d == 2) ? 1'b0 : 1'b1)) begin
          bad++; $display("FAIL lz_dp digit=%0d got=%b want=%b", d, dp_o, (d == 2) ? 1'b0 : 1'b1);
        end
      end
    end
    $display("leading zero test: lz=%0d", LZ);
  endtask

  task automatic test_random();
    int nloads = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      total += 4;
      if (an_o !== exp_an)       begin bad++; $display("FAIL rand_an cyc=%0d got=%h want=%h", cyc, an_o, exp_an); end
      if (seg_o !== exp_seg)     begin bad++; $display("FAIL rand_seg cyc=%0d got=%h want=%h", cyc, seg_o, exp_seg); end
      if (dp_o !== exp_dp)       begin bad++; $display("FAIL rand_dp cyc=%0d got=%b want=%b", cyc, dp_o, exp_dp); end
      if (pending_o !== m_pflag) begin bad++; $display("FAIL rand_pending cyc=%0d got=%b want=%b", cyc, pending_o, m_pflag); end
      load_i = 1'b0;
      if (($urandom_range(0, 9) == 0) || ((cyc % 64 == 63) && $urandom_range(0, 1) == 1)) begin
        bcd_i = $urandom;
        if ($urandom_range(0, 2) == 0) bcd_i = bcd_i >> (4 * $urandom_range(1, 7));
        dp_i   = 8'($urandom);
        load_i = 1'b1;
        nloads++;
      end
    end
    @(negedge clk); load_i = 1'b0;
    $display("random test: loads=%0d", nloads);
  endtask

  initial begin
    test_reset();
    test_guard();
    test_load_frame();
    test_double_load();
    test_boundary_load();
    test_lz();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
